// File: rtl/decode_stage_param.sv
// decode_stage_param: parametrised ID stage.
// Contains the register file, the instruction decoder and the ID/EX pipeline
// register. It also provides stall and flush controls, a valid bit and
// illegal-opcode detection.
// Optional macro DECODE_WB_BYPASS_EN: when it is defined, a register read in
// the same cycle as a qualifying writeback to that register returns ResultW.
// When it is undefined, the read returns the old contents.
module decode_stage_param #(
  parameter int DW    = 19,
  parameter int PCW   = 15,
  parameter int NREGS = 19,
  localparam int RA   = $clog2(NREGS),
  localparam int IW   = 3*RA + 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ValidD,
  input  logic           StallD,
  input  logic           FlushE,
  input  logic [IW-1:0]  InstrD,
  input  logic [PCW-1:0] PCD,
  input  logic           RegWriteW,
  input  logic [RA-1:0]  RdW,
  input  logic [DW-1:0]  ResultW,
  output logic           RegWriteE,
  output logic           MemWriteE,
  output logic           JumpE,
  output logic           ALUSrcE,
  output logic           ResultSrcE,
  output logic           Cant_ByteE,
  output logic           ValidE,
  output logic           IllegalE,
  output logic [1:0]     BranchE,
  output logic [2:0]     ALUControlE,
  output logic [DW-1:0]  RD1E,
  output logic [DW-1:0]  RD2E,
  output logic [DW-1:0]  ImmExtE,
  output logic [PCW-1:0] PCE,
  output logic [RA-1:0]  RDE,
  output logic [RA-1:0]  RS1E,
  output logic [RA-1:0]  RS2E
);

  localparam logic [RA:0] NREGS_W = (RA+1)'(NREGS);

  typedef struct packed {
    logic           reg_write;
    logic           mem_write;
    logic           jump;
    logic           alu_src;
    logic           result_src;
    logic           cant_byte;
    logic           valid;
    logic           illegal;
    logic [1:0]     branch;
    logic [2:0]     alu_ctrl;
    logic [DW-1:0]  rd1;
    logic [DW-1:0]  rd2;
    logic [DW-1:0]  imm;
    logic [PCW-1:0] pc;
    logic [RA-1:0]  rd;
    logic [RA-1:0]  rs1;
    logic [RA-1:0]  rs2;
  } idex_t;

  // Instruction fields
  logic [4:0]    op;
  logic [RA-1:0] rd_f;
  logic [RA-1:0] rs1_f;
  logic [RA-1:0] rs2_f;
  logic [DW-1:0] imm_rs2;
  logic [DW-1:0] imm_rd;
  logic [DW-1:0] imm_j;

  assign op      = InstrD[IW-1:3*RA];
  assign rd_f    = InstrD[3*RA-1:2*RA];
  assign rs1_f   = InstrD[2*RA-1:RA];
  assign rs2_f   = InstrD[RA-1:0];
  assign imm_rs2 = {{(DW-RA){rs2_f[RA-1]}}, rs2_f};
  assign imm_rd  = {{(DW-RA){rd_f[RA-1]}}, rd_f};
  assign imm_j   = {{(DW-3*RA){InstrD[3*RA-1]}}, InstrD[3*RA-1:0]};

  // Register file. r0 is never written, so it always holds zero.
  logic [DW-1:0] rf_q [NREGS];
  logic          wb_en;

  assign wb_en = RegWriteW && (RdW != '0) && ({1'b0, RdW} < NREGS_W);

  // Register-file write port; reset clears every entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[RdW] <= ResultW;
    end
  end

  logic [DW-1:0] rd1_d;
  logic [DW-1:0] rd2_d;

  // Combinational reads; r0 and out-of-range addresses read as zero
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (rs1_f != '0 && {1'b0, rs1_f} < NREGS_W) rd1_d = rf_q[rs1_f];
    if (rs2_f != '0 && {1'b0, rs2_f} < NREGS_W) rd2_d = rf_q[rs2_f];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && rs1_f == RdW) rd1_d = ResultW;
    if (wb_en && rs2_f == RdW) rd2_d = ResultW;
`endif
  end

  // Decoder outputs, before the bubble is applied
  logic          dec_rw, dec_mw, dec_jump, dec_alusrc, dec_rsrc, dec_cb, dec_illegal;
  logic [1:0]    dec_br;
  logic [2:0]    dec_aluc;
  logic [DW-1:0] dec_imm;

  // Opcode decode, grouped by op[4:3]
  always_comb begin
    dec_rw      = 1'b0;
    dec_mw      = 1'b0;
    dec_jump    = 1'b0;
    dec_alusrc  = 1'b0;
    dec_rsrc    = 1'b0;
    dec_cb      = 1'b0;
    dec_illegal = 1'b0;
    dec_br      = 2'b00;
    dec_aluc    = 3'b000;
    dec_imm     = '0;
    case (op[4:3])
      2'b00: begin
        dec_rw   = 1'b1;
        dec_aluc = op[2:0];
      end
      2'b01: begin
        dec_rw     = 1'b1;
        dec_alusrc = 1'b1;
        dec_aluc   = op[2:0];
        dec_imm    = imm_rs2;
      end
      2'b10: begin
        dec_cb = op[0];
        if (op[1]) begin
          dec_illegal = 1'b1;
        end else if (op[2]) begin
          dec_mw     = 1'b1;
          dec_alusrc = 1'b1;
          dec_imm    = imm_rd;
        end else begin
          dec_rw     = 1'b1;
          dec_rsrc   = 1'b1;
          dec_alusrc = 1'b1;
          dec_imm    = imm_rs2;
        end
      end
      2'b11: begin
        case (op[2:0])
          3'b000: begin
            dec_jump = 1'b1;
            dec_imm  = imm_j;
          end
          3'b001, 3'b010, 3'b011: begin
            dec_br  = op[1:0];
            dec_imm = imm_rd;
          end
          3'b100: ;
          default: dec_illegal = 1'b1;
        endcase
      end
    endcase
  end

  idex_t idex_q, idex_d;
  logic  bubble;

  assign bubble = !ValidD || dec_illegal;

  // ID/EX next state. Flush beats stall, and stall beats load.
  always_comb begin
    idex_d = idex_q;
    if (FlushE) begin
      idex_d = '0;
    end else if (!StallD) begin
      idex_d.reg_write  = dec_rw     && !bubble;
      idex_d.mem_write  = dec_mw     && !bubble;
      idex_d.jump       = dec_jump   && !bubble;
      idex_d.alu_src    = dec_alusrc && !bubble;
      idex_d.result_src = dec_rsrc   && !bubble;
      idex_d.cant_byte  = dec_cb     && !bubble;
      idex_d.branch     = bubble ? 2'b00  : dec_br;
      idex_d.alu_ctrl   = bubble ? 3'b000 : dec_aluc;
      idex_d.valid      = !bubble;
      idex_d.illegal    = ValidD && dec_illegal;
      idex_d.rd1        = rd1_d;
      idex_d.rd2        = rd2_d;
      idex_d.imm        = dec_imm;
      idex_d.pc         = PCD;
      idex_d.rd         = rd_f;
      idex_d.rs1        = rs1_f;
      idex_d.rs2        = rs2_f;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign RegWriteE   = idex_q.reg_write;
  assign MemWriteE   = idex_q.mem_write;
  assign JumpE       = idex_q.jump;
  assign ALUSrcE     = idex_q.alu_src;
  assign ResultSrcE  = idex_q.result_src;
  assign Cant_ByteE  = idex_q.cant_byte;
  assign ValidE      = idex_q.valid;
  assign IllegalE    = idex_q.illegal;
  assign BranchE     = idex_q.branch;
  assign ALUControlE = idex_q.alu_ctrl;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign PCE         = idex_q.pc;
  assign RDE         = idex_q.rd;
  assign RS1E        = idex_q.rs1;
  assign RS2E        = idex_q.rs2;

endmodule

// File: tb/tb_decode_stage_param.sv
// Testbench for decode_stage_param. It applies directed and random stimulus
// and compares the DUT against a behavioural model of the decode rules.
module tb_decode_stage_param;
  localparam int DW    = 19;
  localparam int PCW   = 15;
  localparam int NREGS = 19;
  localparam int RA    = $clog2(NREGS);
  localparam int IW    = 3*RA + 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           ValidD, StallD, FlushE;
  logic [IW-1:0]  InstrD;
  logic [PCW-1:0] PCD;
  logic           RegWriteW;
  logic [RA-1:0]  RdW;
  logic [DW-1:0]  ResultW;
  logic           RegWriteE, MemWriteE, JumpE, ALUSrcE, ResultSrcE, Cant_ByteE, ValidE, IllegalE;
  logic [1:0]     BranchE;
  logic [2:0]     ALUControlE;
  logic [DW-1:0]  RD1E, RD2E, ImmExtE;
  logic [PCW-1:0] PCE;
  logic [RA-1:0]  RDE, RS1E, RS2E;

  decode_stage_param #(.DW(DW), .PCW(PCW), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset), .ValidD(ValidD), .StallD(StallD), .FlushE(FlushE),
    .InstrD(InstrD), .PCD(PCD), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .Cant_ByteE(Cant_ByteE), .ValidE(ValidE), .IllegalE(IllegalE),
    .BranchE(BranchE), .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .RDE(RDE), .RS1E(RS1E), .RS2E(RS2E)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Expected ID/EX contents
  typedef struct {
    logic [31:0] rw, mw, jmp, alusrc, rsrc, cb, valid, ill, br, aluc;
    logic [31:0] rd1, rd2, imm, pc, rd, rs1, rs2;
    bit          imm_known;
  } exp_t;

  exp_t        exp_q;
  logic [31:0] mregs [NREGS];

  function automatic exp_t zero_exp();
    exp_t e;
    e.rw = 0; e.mw = 0; e.jmp = 0; e.alusrc = 0; e.rsrc = 0; e.cb = 0;
    e.valid = 0; e.ill = 0; e.br = 0; e.aluc = 0;
    e.rd1 = 0; e.rd2 = 0; e.imm = 0; e.pc = 0; e.rd = 0; e.rs1 = 0; e.rs2 = 0;
    e.imm_known = 1'b1;
    return e;
  endfunction

  function automatic bit wr_ok(input bit we, input int rdw);
    return we && rdw != 0 && rdw < NREGS;
  endfunction

  function automatic logic [31:0] model_read(input int a, input bit we, input int rdw, input logic [31:0] res);
    logic [31:0] v;
    v = (a == 0 || a >= NREGS) ? 32'd0 : mregs[a];
`ifdef DECODE_WB_BYPASS_EN
    if (wr_ok(we, rdw) && a == rdw) v = res;
`endif
    return v;
  endfunction

  // Sign-extend a 'bits'-wide field and keep DW bits
  function automatic logic [31:0] sx(input int f, input int bits);
    int v;
    v = f;
    if (f >= (1 << (bits-1))) v = f - (1 << bits);
    return 32'(v) & ((32'd1 << DW) - 32'd1);
  endfunction

  function automatic exp_t model_decode(input bit v, input int ins, input int pc,
                                        input bit we, input int rdw, input logic [31:0] res);
    exp_t e;
    int op, grp, low, rd, rs1, rs2, m;
    bit ill;
    e   = zero_exp();
    m   = (1 << RA) - 1;
    op  = ins >> (3*RA);
    rd  = (ins >> (2*RA)) & m;
    rs1 = (ins >> RA) & m;
    rs2 = ins & m;
    grp = op >> 3;
    low = op & 7;
    ill = 1'b0;
    e.rd = 32'(rd); e.rs1 = 32'(rs1); e.rs2 = 32'(rs2); e.pc = 32'(pc);
    e.rd1 = model_read(rs1, we, rdw, res);
    e.rd2 = model_read(rs2, we, rdw, res);
    case (grp)
      0: begin e.rw = 1; e.aluc = 32'(low); end
      1: begin e.rw = 1; e.alusrc = 1; e.aluc = 32'(low); e.imm = sx(rs2, RA); end
      2: begin
        if ((low & 2) != 0) ill = 1'b1;
        else begin
          e.cb = 32'(low & 1);
          e.alusrc = 1;
          if ((low & 4) != 0) begin e.mw = 1; e.imm = sx(rd, RA); end
          else begin e.rw = 1; e.rsrc = 1; e.imm = sx(rs2, RA); end
        end
      end
      default: begin
        if (low == 0) begin e.jmp = 1; e.imm = sx(ins & ((1 << (3*RA)) - 1), 3*RA); end
        else if (low <= 3) begin e.br = 32'(low); e.imm = sx(rd, RA); end
        else if (low != 4) ill = 1'b1;
      end
    endcase
    e.imm_known = !ill;
    if (!v || ill) begin
      e.rw = 0; e.mw = 0; e.jmp = 0; e.alusrc = 0; e.rsrc = 0; e.cb = 0; e.br = 0; e.aluc = 0;
    end
    e.valid = 32'(v && !ill);
    e.ill   = 32'(v && ill);
    return e;
  endfunction

  task automatic check_all(input string ctx);
    check_val({ctx, ":RegWriteE"},   32'(RegWriteE),   exp_q.rw);
    check_val({ctx, ":MemWriteE"},   32'(MemWriteE),   exp_q.mw);
    check_val({ctx, ":JumpE"},       32'(JumpE),       exp_q.jmp);
    check_val({ctx, ":ALUSrcE"},     32'(ALUSrcE),     exp_q.alusrc);
    check_val({ctx, ":ResultSrcE"},  32'(ResultSrcE),  exp_q.rsrc);
    check_val({ctx, ":Cant_ByteE"},  32'(Cant_ByteE),  exp_q.cb);
    check_val({ctx, ":ValidE"},      32'(ValidE),      exp_q.valid);
    check_val({ctx, ":IllegalE"},    32'(IllegalE),    exp_q.ill);
    check_val({ctx, ":BranchE"},     32'(BranchE),     exp_q.br);
    check_val({ctx, ":ALUControlE"}, 32'(ALUControlE), exp_q.aluc);
    check_val({ctx, ":RD1E"},        32'(RD1E),        exp_q.rd1);
    check_val({ctx, ":RD2E"},        32'(RD2E),        exp_q.rd2);
    if (exp_q.imm_known) check_val({ctx, ":ImmExtE"}, 32'(ImmExtE), exp_q.imm);
    check_val({ctx, ":PCE"},         32'(PCE),         exp_q.pc);
    check_val({ctx, ":RDE"},         32'(RDE),         exp_q.rd);
    check_val({ctx, ":RS1E"},        32'(RS1E),        exp_q.rs1);
    check_val({ctx, ":RS2E"},        32'(RS2E),        exp_q.rs2);
  endtask

  // One clock of stimulus. It is called just after a negedge and returns at the next negedge.
  task automatic step(input string ctx, input bit v, input bit st, input bit fl,
                      input logic [IW-1:0] ins, input logic [PCW-1:0] pc,
                      input bit we, input logic [RA-1:0] rdw, input logic [DW-1:0] res);
    ValidD = v; StallD = st; FlushE = fl; InstrD = ins; PCD = pc;
    RegWriteW = we; RdW = rdw; ResultW = res;
    if (fl)       exp_q = zero_exp();
    else if (!st) exp_q = model_decode(v, int'(ins), int'(pc), we, int'(rdw), 32'(res));
    if (wr_ok(we, int'(rdw))) mregs[int'(rdw)] = 32'(res);
    $display("%s v=%0b st=%0b fl=%0b instr=%05h pc=%04h wb=%0b r%0d<=%05h",
             ctx, v, st, fl, ins, pc, we, rdw, res);
    @(posedge clk);
    #1;
    check_all(ctx);
    @(negedge clk);
  endtask

  task automatic clear_model();
    exp_q = zero_exp();
    for (int i = 0; i < NREGS; i++) mregs[i] = 32'd0;
  endtask

  // Asserts reset between edges while a valid instruction and a write are presented
  task automatic do_reset(input string ctx, input logic [IW-1:0] ins);
    ValidD = 1'b1; StallD = 1'b0; FlushE = 1'b0; InstrD = ins; PCD = 15'h0123;
    RegWriteW = 1'b1; RdW = 5'd1; ResultW = 19'h0ABCD;
    reset = 1'b1;
    #1;
    clear_model();
    $display("%s reset asserted mid-cycle instr=%05h", ctx, ins);
    check_all({ctx, "_async"});
    @(posedge clk);
    #1;
    check_all({ctx, "_hold"});
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ValidD = 1'b0; StallD = 1'b0; FlushE = 1'b0; InstrD = '0; PCD = '0;
    RegWriteW = 1'b1; RdW = 5'd1; ResultW = 19'd5;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    reset = 1'b0;

    // A write attempted during reset must not have landed in r1
    step("rst_r1", 1, 0, 0, 20'h00C22, 15'h0004, 0, 5'd0, 19'd0);
    check_val("rst_r1_read", 32'(RD1E), 32'd0);

    step("wr_r1", 0, 0, 0, 20'h00000, 15'h0000, 1, 5'd1, 19'd5);
    step("wr_r2", 0, 0, 0, 20'h00000, 15'h0000, 1, 5'd2, 19'd7);
    step("add", 1, 0, 0, 20'h00C22, 15'h0010, 0, 5'd0, 19'd0);
    check_val("add_rd1", 32'(RD1E), 32'd5);
    check_val("add_rd2", 32'(RD2E), 32'd7);
    check_val("add_rde", 32'(RDE), 32'd3);
    step("load", 1, 0, 0, 20'h8103F, 15'h0011, 0, 5'd0, 19'd0);
    check_val("load_imm", 32'(ImmExtE), 32'h7FFFF);
    check_val("load_rsrc", 32'(ResultSrcE), 32'd1);
    step("jump", 1, 0, 0, 20'hC4000, 15'h0012, 0, 5'd0, 19'd0);
    check_val("jump_imm", 32'(ImmExtE), 32'h7C000);
    check_val("jump_j", 32'(JumpE), 32'd1);
    step("stall1", 1, 1, 0, 20'h00C22, 15'h0013, 0, 5'd0, 19'd0);
    step("stall2", 1, 1, 0, 20'h8103F, 15'h0014, 0, 5'd0, 19'd0);
    check_val("stall_imm", 32'(ImmExtE), 32'h7C000);
    step("flush_stall", 1, 1, 1, 20'h00C22, 15'h0015, 0, 5'd0, 19'd0);
    check_val("flush_valid", 32'(ValidE), 32'd0);
    step("illegal", 1, 0, 0, 20'hE8000, 15'h0016, 0, 5'd0, 19'd0);
    check_val("illegal_flag", 32'(IllegalE), 32'd1);
    step("wr_r0", 0, 0, 0, 20'h00000, 15'h0000, 1, 5'd0, 19'h12345);
    step("read_r0", 1, 0, 0, 20'h00000, 15'h0017, 0, 5'd0, 19'd0);
    check_val("r0_zero", 32'(RD1E), 32'd0);
    step("bypass", 1, 0, 0, 20'h00C22, 15'h0018, 1, 5'd1, 19'd9);
`ifdef DECODE_WB_BYPASS_EN
    check_val("bypass_rd1", 32'(RD1E), 32'd9);
`else
    check_val("bypass_rd1", 32'(RD1E), 32'd5);
`endif
    step("after_wr", 1, 0, 0, 20'h00C22, 15'h0019, 0, 5'd0, 19'd0);
    check_val("r1_new", 32'(RD1E), 32'd9);
    do_reset("rst_mid", 20'h00C22);

    for (int i = 0; i < 400; i++) begin
      logic [IW-1:0]  ins;
      logic [RA-1:0]  rdw;
      bit             v, st, fl, we;
      ins = IW'($urandom);
      v   = ($urandom_range(0, 9) < 8);
      st  = ($urandom_range(0, 9) < 2);
      fl  = ($urandom_range(0, 9) == 0);
      we  = ($urandom_range(0, 3) != 0);
      rdw = RA'($urandom);
      if ($urandom_range(0, 3) == 0) rdw = ins[2*RA-1:RA];
      if (i == 200) do_reset("rst_rand", ins);
      step("rand", v, st, fl, ins, PCW'($urandom), we, rdw, DW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
